lc3_datapath_memctl: RTL

//  LC-3 datapath (PC, IR, MAR, MDR, 8-entry reg file, ALU, NZP/BEN, LED latch) with a built-in memory

---
 rtl/lc3_datapath_memctl_if.sv | 25 ++
 rtl/lc3_datapath_memctl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/lc3_datapath_memctl_if.sv
// Memory handshake bundle between the LC-3 datapath (master) and the SRAM/IO side.
// The master modport drives the request, address and write data, and returns the status signals.
interface lc3_datapath_memctl_if;
   logic        Mem_Start;
   logic        Mem_WE;
   logic        Mem_Ack;
   logic [15:0] Mem_Rdata;
   logic        Mem_Req;
   logic        Mem_Wr;
   logic [15:0] Mem_Addr;
   logic [15:0] Mem_Wdata;
   logic        Mem_Busy;
   logic        Mem_Done;
   logic        Mem_Err;

   modport master (
      input  Mem_Start, Mem_WE, Mem_Ack, Mem_Rdata,
      output Mem_Req, Mem_Wr, Mem_Addr, Mem_Wdata, Mem_Busy, Mem_Done, Mem_Err
   );

   modport slave (
      output Mem_Start, Mem_WE, Mem_Ack, Mem_Rdata,
      input  Mem_Req, Mem_Wr, Mem_Addr, Mem_Wdata, Mem_Busy, Mem_Done, Mem_Err
   );
endinterface

// File: rtl/lc3_datapath_memctl.sv
// LC-3 datapath (PC, IR, MAR, MDR, register file, ALU, NZP/BEN, LED) with an integrated
// memory request/acknowledge FSM that owns MDR loads from memory and aborts on timeout.
module lc3_datapath_memctl #(
   parameter logic [15:0] PC_RESET    = 16'h3000,
   parameter int          LED_W       = 12,
   parameter int          MEM_TIMEOUT = 15
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   input  logic                 LD_PC,
   input  logic                 LD_IR,
   input  logic                 LD_MAR,
   input  logic                 LD_MDR,
   input  logic                 LD_BEN,
   input  logic                 LD_CC,
   input  logic                 LD_REG,
   input  logic                 LD_LED,
   input  logic                 GatePC,
   input  logic                 GateMDR,
   input  logic                 GateALU,
   input  logic                 GateMARMUX,
   input  logic [1:0]           PCMUX,
   input  logic [1:0]           ADDR2MUX,
   input  logic                 ADDR1MUX,
   input  logic                 SR1MUX,
   input  logic                 DRMUX,
   input  logic [1:0]           ALUK,
   lc3_datapath_memctl_if.master mem,
   output logic                 Bus_Err,
   output logic [15:0]          IR,
   output logic [15:0]          PC,
   output logic [15:0]          MAR,
   output logic [15:0]          MDR,
   output logic [LED_W-1:0]     LED,
   output logic                 N,
   output logic                 Z,
   output logic                 P,
   output logic                 BEN
);

   localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_DONE = 2'b10
   } mem_state_t;

   mem_state_t       state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             req_r;
   logic             wr_r;
   logic             busy_r;
   logic             done_r;
   logic             err_r;

   logic [15:0] regs_r [8];
   logic [2:0]  sr1_sel_s;
   logic [2:0]  dr_sel_s;
   logic [15:0] sr1_out_s;
   logic [15:0] alu_b_s;
   logic [15:0] alu_s;
   logic [15:0] addr1_s;
   logic [15:0] addr2_s;
   logic [15:0] adder_s;
   logic [15:0] bus_s;
   logic [3:0]  gates_s;
   logic        multi_gate_s;

   // True when more than one bus driver is enabled at once.
   function automatic logic multi_gate(input logic [3:0] g);
      return (g & (g - 4'd1)) != 4'd0;
   endfunction

   // Operand selection, address adder, ALU and bus multiplexing.
   always_comb begin
      sr1_sel_s = SR1MUX ? IR[8:6] : IR[11:9];
      dr_sel_s  = DRMUX ? 3'd7 : IR[11:9];
      sr1_out_s = regs_r[sr1_sel_s];
      alu_b_s   = IR[5] ? {{11{IR[4]}}, IR[4:0]} : regs_r[IR[2:0]];
      addr1_s   = ADDR1MUX ? PC : sr1_out_s;
      case (ADDR2MUX)
         2'b00:   addr2_s = {{5{IR[10]}}, IR[10:0]};
         2'b01:   addr2_s = {{7{IR[8]}}, IR[8:0]};
         2'b10:   addr2_s = {{10{IR[5]}}, IR[5:0]};
         default: addr2_s = 16'h0000;
      endcase
      adder_s = addr1_s + addr2_s;
      case (ALUK)
         2'b00:   alu_s = sr1_out_s + alu_b_s;
         2'b01:   alu_s = sr1_out_s & alu_b_s;
         2'b10:   alu_s = ~sr1_out_s;
         default: alu_s = sr1_out_s;
      endcase
      gates_s      = {GatePC, GateMDR, GateALU, GateMARMUX};
      multi_gate_s = multi_gate(gates_s);
      case (gates_s)
         4'b1000: bus_s = PC;
         4'b0100: bus_s = MDR;
         4'b0010: bus_s = alu_s;
         4'b0001: bus_s = adder_s;
         default: bus_s = 16'h0000;
      endcase
   end

   // Architectural registers, condition codes, LED latch and sticky bus-contention flag.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         PC      <= PC_RESET;
         IR      <= 16'h0000;
         MAR     <= 16'h0000;
         LED     <= '0;
         N       <= 1'b0;
         Z       <= 1'b1;
         P       <= 1'b0;
         BEN     <= 1'b0;
         Bus_Err <= 1'b0;
         for (int i = 0; i < 8; i++) regs_r[i] <= 16'h0000;
      end else begin
         if (LD_PC) begin
            case (PCMUX)
               2'b00:   PC <= bus_s;
               2'b01:   PC <= adder_s;
               2'b10:   PC <= PC + 16'd1;
               default: PC <= PC;
            endcase
         end
         if (LD_IR)  IR  <= bus_s;
         if (LD_MAR) MAR <= bus_s;
         if (LD_LED) LED <= IR[LED_W-1:0];
         if (LD_REG) regs_r[dr_sel_s] <= bus_s;
         if (LD_CC) begin
            N <= bus_s[15];
            Z <= (bus_s == 16'h0000);
            P <= !bus_s[15] && (bus_s != 16'h0000);
         end
         // Branch enable deliberately uses the NZP already held, not this cycle's update.
         if (LD_BEN) BEN <= (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);
         if (multi_gate_s) Bus_Err <= 1'b1;
      end
   end

   // Memory handshake FSM; also the only writer of MDR so bus loads and memory loads never race.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
         req_r   <= 1'b0;
         wr_r    <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
         MDR     <= 16'h0000;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (LD_MDR) MDR <= bus_s;
               if (mem.Mem_Start) begin
                  state_r <= ST_REQ;
                  req_r   <= 1'b1;
                  wr_r    <= mem.Mem_WE;
                  busy_r  <= 1'b1;
                  cnt_r   <= '0;
               end
            end
            ST_REQ: begin
               if (mem.Mem_Ack) begin
                  state_r <= ST_DONE;
                  req_r   <= 1'b0;
                  done_r  <= 1'b1;
                  if (!wr_r) MDR <= mem.Mem_Rdata;
               end else if (cnt_r == CNT_LAST) begin
                  state_r <= ST_DONE;
                  req_r   <= 1'b0;
                  done_r  <= 1'b1;
                  err_r   <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r <= ST_IDLE;
               req_r   <= 1'b0;
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign mem.Mem_Req   = req_r;
   assign mem.Mem_Wr    = wr_r;
   assign mem.Mem_Busy  = busy_r;
   assign mem.Mem_Done  = done_r;
   assign mem.Mem_Err   = err_r;
   assign mem.Mem_Addr  = MAR;
   assign mem.Mem_Wdata = MDR;

endmodule
